// File: rtl/fifo_wr_ptr_cntrl.sv
// Write-side pointer controller for an asynchronous FIFO.
// Keeps the binary write pointer, drives the memory write address/enable,
// publishes a Gray-coded pointer for the read-side synchronizer and derives
// full / almost-full / occupancy from the synchronized Gray read pointer.
// Optional sticky overflow flag (wovf): define FIFO_WR_OVF_FLAG_EN.
// Reset is synchronous and active-high.
module fifo_wr_ptr_cntrl #(
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wclken,
  output logic                  wfull,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wafull,
  output logic [ADDR_WIDTH:0]   wlevel
`ifdef FIFO_WR_OVF_FLAG_EN
  ,
  output logic                  wovf
`endif
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  // Full when the write pointer leads the read pointer by exactly one lap:
  // in Gray code that is the read pointer with its two MSBs inverted.
  localparam logic [ADDR_WIDTH:0] FullMask    = PtrW'(3) << (ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] AfullThresh = PtrW'(AFULL_THRESH);

  logic [ADDR_WIDTH:0] wbin_q, wbin_d;
  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] wlevel_q, wlevel_d;
  logic                wfull_q, wfull_d;
  logic                wafull_q, wafull_d;
  logic [ADDR_WIDTH:0] rbin;

  // Memory-side outputs come straight from registered state.
  always_comb begin
    waddr  = wbin_q[ADDR_WIDTH-1:0];
    wclken = winc & ~wfull_q;
    wptr   = wptr_q;
    wfull  = wfull_q;
    wafull = wafull_q;
    wlevel = wlevel_q;
  end

  // Next pointer, Gray encoding and flag/occupancy computation.
  always_comb begin
    rbin = '0;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (int unsigned i = 0; i < PtrW; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
    wbin_d   = wbin_q + {{ADDR_WIDTH{1'b0}}, wclken};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    wfull_d  = (wptr_d == (wq2_rptr ^ FullMask));
    wlevel_d = wbin_d - rbin;
    wafull_d = (wlevel_d >= AfullThresh);
  end

  // Pointer and flag registers; synchronous reset wins over writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
    end
  end

`ifdef FIFO_WR_OVF_FLAG_EN
  logic wovf_q, wovf_d;

  // Sticky: any write attempt while full latches until reset.
  always_comb begin
    wovf_d = wovf_q | (winc & wfull_q);
    wovf   = wovf_q;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wovf_q <= 1'b0;
    end else begin
      wovf_q <= wovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_cntrl.sv
// Self-checking bench for fifo_wr_ptr_cntrl (ADDR_WIDTH=3, AFULL_THRESH=6).
// Directed vector table, hand sequences for wrap/reset corners, then random
// traffic checked against an occupancy-counting reference model.
module tb_fifo_wr_ptr_cntrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [3:0] wq2_rptr;
  logic [2:0] waddr;
  logic       wclken;
  logic       wfull;
  logic [3:0] wptr;
  logic       wafull;
  logic [3:0] wlevel;
`ifdef FIFO_WR_OVF_FLAG_EN
  logic       wovf;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  fifo_wr_ptr_cntrl #(
    .ADDR_WIDTH  (3),
    .AFULL_THRESH(6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .winc    (winc),
    .wq2_rptr(wq2_rptr),
    .waddr   (waddr),
    .wclken  (wclken),
    .wfull   (wfull),
    .wptr    (wptr),
    .wafull  (wafull),
    .wlevel  (wlevel)
`ifdef FIFO_WR_OVF_FLAG_EN
    ,
    .wovf    (wovf)
`endif
  );

  typedef struct {
    logic       rst;
    logic       winc;
    logic [3:0] rptr;
    logic       chk_clken;
    logic       clken;
    logic       chk_out;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       full;
    logic       afull;
    logic [3:0] level;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic w, input logic [3:0] p,
                              input logic cc, input logic ce, input logic co,
                              input logic [2:0] a, input logic [3:0] g, input logic f,
                              input logic af, input logic [3:0] lv, input logic ov);
    vec_t v;
    v.rst = r; v.winc = w; v.rptr = p; v.chk_clken = cc; v.clken = ce; v.chk_out = co;
    v.waddr = a; v.wptr = g; v.full = f; v.afull = af; v.level = lv; v.ovf = ov;
    vecs.push_back(v);
  endfunction

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] a, input logic [3:0] g,
                            input logic f, input logic af, input logic [3:0] lv,
                            input logic ov);
    check({tag, ".waddr"},  32'(waddr),  32'(a));
    check({tag, ".wptr"},   32'(wptr),   32'(g));
    check({tag, ".wfull"},  32'(wfull),  32'(f));
    check({tag, ".wafull"}, 32'(wafull), 32'(af));
    check({tag, ".wlevel"}, 32'(wlevel), 32'(lv));
`ifdef FIFO_WR_OVF_FLAG_EN
    check({tag, ".wovf"},   32'(wovf),   32'(ov));
`else
    if (ov === 1'bx) check({tag, ".ovf_unused"}, 32'(ov), 32'(1'b0));
`endif
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] p);
    rst = r; winc = w; wq2_rptr = p;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // Random-phase reference model: counts writes and reads mod 16.
  int  mw, mrd, mlevel;
  logic mfull, mafull, movf;

  initial begin
    drive(1'b1, 1'b0, 4'b0000);
    #2;

    // Reset, fill to full, write while full, read one, refill.
    //   rst winc rptr     cc ce co addr wptr    f  af lvl ovf
    add(1, 1, 4'b0000,  0, 0, 1, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 1, 4'b0000,  1, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 1, 4'b0000,  1, 1, 1, 1, 4'b0001, 0, 0, 1, 0);
    add(0, 1, 4'b0000,  1, 1, 1, 2, 4'b0011, 0, 0, 2, 0);
    add(0, 1, 4'b0000,  1, 1, 1, 3, 4'b0010, 0, 0, 3, 0);
    add(0, 1, 4'b0000,  1, 1, 1, 4, 4'b0110, 0, 0, 4, 0);
    add(0, 1, 4'b0000,  1, 1, 1, 5, 4'b0111, 0, 0, 5, 0);
    add(0, 1, 4'b0000,  1, 1, 1, 6, 4'b0101, 0, 1, 6, 0);
    add(0, 1, 4'b0000,  1, 1, 1, 7, 4'b0100, 0, 1, 7, 0);
    add(0, 1, 4'b0000,  1, 1, 1, 0, 4'b1100, 1, 1, 8, 0);
    add(0, 1, 4'b0000,  1, 0, 1, 0, 4'b1100, 1, 1, 8, 1);
    add(0, 1, 4'b0000,  1, 0, 1, 0, 4'b1100, 1, 1, 8, 1);
    add(0, 1, 4'b0000,  1, 0, 1, 0, 4'b1100, 1, 1, 8, 1);
    add(0, 0, 4'b0001,  1, 0, 1, 0, 4'b1100, 0, 1, 7, 1);
    add(0, 1, 4'b0001,  1, 1, 1, 1, 4'b1101, 1, 1, 8, 1);
    // Reader catches up to 4 -> level 5, then reset with a pending write.
    add(0, 0, 4'b0110,  1, 0, 1, 1, 4'b1101, 0, 0, 5, 1);
    add(1, 1, 4'b0110,  1, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 1, 4'b0000,  1, 1, 1, 1, 4'b0001, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].winc, vecs[i].rptr);
      #1;
      if (vecs[i].chk_clken) check($sformatf("vec%0d.wclken", i), 32'(wclken),
                                   32'(vecs[i].clken));
      edge_wait();
      if (vecs[i].chk_out) check_outs($sformatf("vec%0d", i), vecs[i].waddr, vecs[i].wptr,
                                      vecs[i].full, vecs[i].afull, vecs[i].level,
                                      vecs[i].ovf);
    end

    // 16 writes with the read pointer trailing wptr by two edges: never full,
    // pointer wraps back to zero.
    begin
      logic [3:0] hist[$];
      drive(1'b1, 1'b1, 4'b0000);
      edge_wait();
      hist.push_back(4'b0000);
      hist.push_back(4'b0000);
      for (int k = 1; k <= 16; k++) begin
        drive(1'b0, 1'b1, hist.pop_front());
        edge_wait();
        check($sformatf("lag%0d.wfull", k), 32'(wfull), 32'(1'b0));
        check($sformatf("lag%0d.wptr", k),  32'(wptr),  32'(gray(k)));
        hist.push_back(wptr);
      end
      check("lag.final_waddr", 32'(waddr), 32'(0));
    end

    // Random traffic against the occupancy model.
    drive(1'b1, 1'b0, 4'b0000);
    edge_wait();
    mw = 0; mrd = 0; mlevel = 0; mfull = 0; mafull = 0; movf = 0;
    for (int c = 0; c < 400; c++) begin
      logic r, w;
      r = ($urandom_range(0, 99) < 3);
      w = ($urandom_range(0, 99) < 65);
      if (((mw - mrd) & 15) != 0 && $urandom_range(0, 1) == 1) mrd = (mrd + 1) & 15;
      drive(r, w, gray(mrd));
      #1;
      check($sformatf("rnd%0d.wclken", c), 32'(wclken), 32'(w && !mfull));
      edge_wait();
      if (r) begin
        mw = 0; mrd = 0; mlevel = 0; mfull = 0; mafull = 0; movf = 0;
      end else begin
        movf = movf | (w & mfull);
        if (w && !mfull) mw = (mw + 1) & 15;
        mlevel = (mw - mrd) & 15;
        mfull  = (mlevel == 8);
        mafull = (mlevel >= 6);
      end
      check_outs($sformatf("rnd%0d", c), 3'(mw), gray(mw), mfull, mafull, 4'(mlevel), movf);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
